rf_wport_arbiter: RTL

//  Shares the single register-file write port between the in-order WB stage and a

---
 rtl/rf_wport_arbiter_if.sv | 36 +++
 rtl/rf_wport_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter_if.sv
// rtl/rf_wport_arbiter_if.sv - WB / long-latency / regfile write-port bundle (optional RF_WPORT_ARB_STATS_EN counters)
interface rf_wport_arbiter_if;
    logic        wb_valid;
    logic [37:0] wb_rf_zip;
    logic        wb_stall;
    logic        lu_valid;
    logic [37:0] lu_rf_zip;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RF_WPORT_ARB_STATS_EN
    logic [31:0] arb_wb_stall_cnt;
    logic [31:0] arb_lu_drop_cnt;

    modport slave (
        input  wb_valid, wb_rf_zip, lu_valid, lu_rf_zip,
        output wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata,
        output arb_wb_stall_cnt, arb_lu_drop_cnt
    );
    modport master (
        output wb_valid, wb_rf_zip, lu_valid, lu_rf_zip,
        input  wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata,
        input  arb_wb_stall_cnt, arb_lu_drop_cnt
    );
`else
    modport slave (
        input  wb_valid, wb_rf_zip, lu_valid, lu_rf_zip,
        output wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );
    modport master (
        output wb_valid, wb_rf_zip, lu_valid, lu_rf_zip,
        input  wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );
`endif
endinterface

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - regfile write-port arbiter, WB priority with starvation-forced FIFO drain (optional RF_WPORT_ARB_STATS_EN)
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    rf_wport_arbiter_if.slave bus
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

    // FIFO holds only {waddr, wdata}; the we bit is implicit because no-op writes are never stored
    logic [36:0]   fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    logic wb_req, fifo_req, grant_lu, grant_wb;
    logic full, empty, lu_fire, lu_keep;
    logic [36:0] head;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign head     = fifo_q[rd_ptr_q];

    assign wb_req   = bus.wb_valid & bus.wb_rf_zip[37] & (bus.wb_rf_zip[36:32] != 5'd0);
    assign fifo_req = ~empty;
    assign grant_lu = fifo_req & (~wb_req | (starve_q == LIMIT));
    assign grant_wb = wb_req & ~grant_lu;

    // A full FIFO refuses even when it pops this cycle, keeping lu_ready independent of the grant
    assign lu_fire  = bus.lu_valid & ~full;
    assign lu_keep  = lu_fire & bus.lu_rf_zip[37] & (bus.lu_rf_zip[36:32] != 5'd0);

    assign bus.wb_stall = wb_req & grant_lu;
    assign bus.lu_ready = ~full;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    // next-state for pointers, occupancy, starvation counter and the registered write stage
    always_comb begin
        wr_ptr_d   = lu_keep  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = grant_lu ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({lu_keep, grant_lu})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (empty || grant_lu)
            starve_d = 4'd0;
        else if (grant_wb && (starve_q != LIMIT))
            starve_d = starve_q + 4'd1;

        rf_we_d    = grant_wb | grant_lu;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_lu) begin
            rf_waddr_d = head[36:32];
            rf_wdata_d = head[31:0];
        end else if (grant_wb) begin
            rf_waddr_d = bus.wb_rf_zip[36:32];
            rf_wdata_d = bus.wb_rf_zip[31:0];
        end
    end

    // control state; reset drops queued entries by clearing pointers and count
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge clk) begin
        if (lu_keep)
            fifo_q[wr_ptr_q] <= bus.lu_rf_zip[36:0];
    end

`ifdef RF_WPORT_ARB_STATS_EN
    logic [31:0] stall_cnt_q, drop_cnt_q;

    assign bus.arb_wb_stall_cnt = stall_cnt_q;
    assign bus.arb_lu_drop_cnt  = drop_cnt_q;

    // free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            if (bus.wb_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (lu_fire && !lu_keep)
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
`endif
endmodule
